tone_detector: RTL

- Receive-side counterpart of the square-wave note generators.
- Measures the period of an asynchronous square wave (`tone_in`) in clock cycles.
- Classifies the period as C4 (261.63 Hz), E4 (329.63 Hz), G4 (392.00 Hz) or none.
- Reports a stable note only after a programmable number of consecutive matching periods. The board uses it to light an LED for a note played into a GPIO.

---
 rtl/tone_detector.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tone_detector.sv
// Square-wave period meter and C4/E4/G4 note classifier with N-period confirmation.
// Optional duty-cycle qualification is built when TONE_DETECTOR_DUTY_CHECK_EN is defined.
module tone_detector #(
  parameter int unsigned clock_frequency      = 12000000,
  parameter int unsigned frequency_c4_mul_100 = 26163,
  parameter int unsigned frequency_e4_mul_100 = 32963,
  parameter int unsigned frequency_g4_mul_100 = 39200,
  parameter int unsigned tolerance_percent    = 2,
  parameter int unsigned confirm_periods      = 4,
  parameter int unsigned timeout_cycles       = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tone_in,
  output logic [16:0] period,
  output logic        period_valid,
  output logic [1:0]  note_code,
  output logic        note_valid,
  output logic        signal_lost
);

  localparam longint unsigned NOM_C4 = longint'(clock_frequency) * 100 / longint'(frequency_c4_mul_100);
  localparam longint unsigned NOM_E4 = longint'(clock_frequency) * 100 / longint'(frequency_e4_mul_100);
  localparam longint unsigned NOM_G4 = longint'(clock_frequency) * 100 / longint'(frequency_g4_mul_100);
  localparam longint unsigned DEL_C4 = NOM_C4 * tolerance_percent / 100;
  localparam longint unsigned DEL_E4 = NOM_E4 * tolerance_percent / 100;
  localparam longint unsigned DEL_G4 = NOM_G4 * tolerance_percent / 100;

  localparam logic [16:0] LO_C4 = 17'(NOM_C4 - DEL_C4);
  localparam logic [16:0] HI_C4 = 17'(NOM_C4 + DEL_C4);
  localparam logic [16:0] LO_E4 = 17'(NOM_E4 - DEL_E4);
  localparam logic [16:0] HI_E4 = 17'(NOM_E4 + DEL_E4);
  localparam logic [16:0] LO_G4 = 17'(NOM_G4 - DEL_G4);
  localparam logic [16:0] HI_G4 = 17'(NOM_G4 + DEL_G4);

  localparam logic [16:0] TIMEOUT = 17'(timeout_cycles);
  localparam logic [3:0]  CONFIRM = 4'(confirm_periods);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] period_q, period_d;
  logic        period_valid_q, period_valid_d;
  logic [1:0]  note_code_q, note_code_d;
  logic        note_valid_q, note_valid_d;
  logic [3:0]  match_q, match_d;
  logic [1:0]  prev_cls_q, prev_cls_d;
  logic        rise;
  logic [1:0]  cls;
  logic        duty_ok;

`ifdef TONE_DETECTOR_DUTY_CHECK_EN
  logic [16:0] high_q, high_d;
  logic [18:0] twice_high;
  logic [18:0] per_ext;
  logic [18:0] duty_err;

  // Measured period is cnt_q cycles; the high counter spans exactly the same cycles.
  always_comb begin
    twice_high = {1'b0, high_q, 1'b0};
    per_ext    = {2'b00, cnt_q};
    duty_err   = (twice_high >= per_ext) ? (twice_high - per_ext) : (per_ext - twice_high);
    duty_ok    = (duty_err <= (per_ext >> 3));
  end
`else
  assign duty_ok = 1'b1;
`endif

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    cls = 2'd0;
    if (cnt_q >= LO_C4 && cnt_q <= HI_C4)      cls = 2'd1;
    else if (cnt_q >= LO_E4 && cnt_q <= HI_E4) cls = 2'd2;
    else if (cnt_q >= LO_G4 && cnt_q <= HI_G4) cls = 2'd3;
    if (!duty_ok) cls = 2'd0;
  end

  always_comb begin
    sync_d         = {sync_q[1:0], tone_in};
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    note_code_d    = note_code_q;
    note_valid_d   = note_valid_q;
    match_d        = match_q;
    prev_cls_d     = prev_cls_q;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
    high_d         = high_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
        high_d = '0;
`endif
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = 17'd1;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
          high_d  = 17'd1;
`endif
        end
      end
      MEASURE: begin
        if (rise) begin
          // An edge coinciding with timeout is still a measurement (period = TIMEOUT).
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          cnt_d          = 17'd1;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
          high_d         = 17'd1;
`endif
          prev_cls_d     = cls;
          if (cls == 2'd0) begin
            match_d      = '0;
            note_valid_d = 1'b0;
            note_code_d  = 2'd0;
          end else begin
            if (cls == prev_cls_q) match_d = (match_q >= CONFIRM) ? CONFIRM : match_q + 4'd1;
            else                   match_d = 4'd1;
            note_valid_d = (match_d == CONFIRM);
            note_code_d  = (match_d == CONFIRM) ? cls : 2'd0;
          end
        end else if (cnt_q == TIMEOUT) begin
          state_d      = IDLE;
          cnt_d        = '0;
          note_valid_d = 1'b0;
          note_code_d  = 2'd0;
          match_d      = '0;
          prev_cls_d   = 2'd0;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
          high_d       = '0;
`endif
        end else begin
          cnt_d = cnt_q + 17'd1;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
          high_d = high_q + {16'd0, sync_q[1]};
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sync_q         <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      note_code_q    <= '0;
      note_valid_q   <= 1'b0;
      match_q        <= '0;
      prev_cls_q     <= '0;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
      high_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      note_code_q    <= note_code_d;
      note_valid_q   <= note_valid_d;
      match_q        <= match_d;
      prev_cls_q     <= prev_cls_d;
`ifdef TONE_DETECTOR_DUTY_CHECK_EN
      high_q         <= high_d;
`endif
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign note_code    = note_code_q;
  assign note_valid   = note_valid_q;
  assign signal_lost  = (state_q == IDLE);

endmodule
